// File: rtl/dmem_dma_master_pkg.sv
// Shared types and defaults for the data-memory DMA initiator: op and FSM
// state encodings plus the default geometry and fill word.
package dmem_dma_master_pkg;

    localparam int          AW_DEF     = 6;
    localparam int          DW_DEF     = 32;
    localparam logic [31:0] FILL_DEF_C = 32'hFFFF_FFFF;

    typedef enum logic {
        OP_COPY = 1'b0,
        OP_FILL = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_dma_master_if.sv
// Data-memory port: registered write (we/a/d), combinational read q from a.
interface dmem_dma_master_if
    import dmem_dma_master_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] q;

    modport master (output we, a, d, input q);
    modport slave  (input we, a, d, output q);
endinterface

// File: rtl/dmem_dma_master.sv
// Block COPY/FILL sequencer that owns the data-memory port while busy.
// COPY alternates RD/WR per word, FILL streams one write per cycle.
module dmem_dma_master
    import dmem_dma_master_pkg::*;
#(
    parameter int          AW       = AW_DEF,
    parameter int          DW       = DW_DEF,
    parameter int          LW       = AW + 1,
    parameter logic [DW-1:0] FILL_DEF = DW'(FILL_DEF_C)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          op_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    input  logic          cfg_pat_en_i,
    input  logic [DW-1:0] pattern_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [LW-1:0] words_done_o,
    dmem_dma_master_if.master mem
);

    localparam logic [LW-1:0] FULL_LEN = LW'(2 ** AW);

    state_e        state_q;
    op_e           op_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [LW-1:0] idx_d;
    logic          err_q;
    logic [DW-1:0] wdata_q;
    logic          len_bad;

    assign len_bad = (len_i > FULL_LEN);
    assign idx_d   = idx_q + LW'(1);

    // The word index doubles as the words-written count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q  <= op_e'(op_i);
                        src_q <= src_i;
                        dst_q <= dst_i;
                        len_q <= len_i;
                        idx_q <= '0;
                        err_q <= len_bad;
                        if (len_i == '0 || len_bad)
                            state_q <= S_DONE;
                        else if (op_i == OP_FILL)
                            state_q <= S_WR;
                        else
                            state_q <= S_RD;
                    end
                end
                S_RD: state_q <= S_WR;
                S_WR: begin
                    idx_q <= idx_d;
                    if (idx_d == len_q)
                        state_q <= S_DONE;
                    else if (op_q == OP_COPY)
                        state_q <= S_RD;
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write data holds the fill word from start, or the word fetched in RD.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start_i)
            wdata_q <= cfg_pat_en_i ? pattern_i : FILL_DEF;
        else if (state_q == S_RD)
            wdata_q <= mem.q;
    end

    assign busy_o       = (state_q == S_RD) || (state_q == S_WR);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_DONE) && err_q;
    assign words_done_o = idx_q;

    // Addresses wrap naturally in AW bits.
    assign mem.we = (state_q == S_WR);
    assign mem.a  = (state_q == S_WR) ? dst_q + idx_q[AW-1:0] :
                    (state_q == S_RD) ? src_q + idx_q[AW-1:0] : '0;
    assign mem.d  = (state_q == S_WR) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_dma_master.sv
// Randomised scoreboard bench for dmem_dma_master driving a behavioural data memory.
module tb_dmem_dma_master;
    import dmem_dma_master_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LW = AW + 1;
    localparam int N  = 2 ** AW;
    localparam logic [DW-1:0] FILL_W = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          op_i;
    logic [AW-1:0] src_i;
    logic [AW-1:0] dst_i;
    logic [LW-1:0] len_i;
    logic          cfg_pat_en_i;
    logic [DW-1:0] pattern_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [LW-1:0] words_done_o;

    dmem_dma_master_if #(.AW(AW), .DW(DW)) mif ();

    dmem_dma_master #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .op_i         (op_i),
        .src_i        (src_i),
        .dst_i        (dst_i),
        .len_i        (len_i),
        .cfg_pat_en_i (cfg_pat_en_i),
        .pattern_i    (pattern_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_done_o (words_done_o),
        .mem          (mif)
    );

    // Behavioural data memory with a one-cycle bulk load used only while idle
    logic [DW-1:0] mem      [N];
    logic [DW-1:0] load_img [N];
    logic          tb_load;

    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < N; i++) mem[i] <= load_img[i];
        end else if (mif.we) begin
            mem[mif.a] <= mif.d;
        end
    end
    assign mif.q = mem[mif.a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic                   err;
        logic [LW-1:0]          wd;
        int                     done_cyc;
        int                     busy_cyc;
        logic [N-1:0][DW-1:0]   img;
    } exp_t;

    exp_t          sbq [$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] img     [N];
    int            checks   = 0;
    int            errors   = 0;
    int            busy_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_mem(input string nm, input logic [N-1:0][DW-1:0] expimg);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== expimg[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d words differ, first word %0d got %h expected %h",
                     nm, bad, first, mem[first], expimg[first]);
        end
    endtask

    function automatic logic [N-1:0][DW-1:0] ref_snapshot();
        logic [N-1:0][DW-1:0] s;
        for (int i = 0; i < N; i++) s[i] = ref_mem[i];
        return s;
    endfunction

    // Monitor: pops the expected outcome whenever the DUT signals done
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (mif.we) chk("we_only_when_busy", busy_o, 1);
            if (done_o) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("done_err", err_o, mon_e.err);
                    chk("done_words_done", words_done_o, mon_e.wd);
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("busy_cycles", busy_cnt, mon_e.busy_cyc);
                    chk("busy_low_at_done", busy_o, 0);
                    chk_mem("mem_image", mon_e.img);
                end
                busy_cnt = 0;
            end else if (busy_o) begin
                busy_cnt++;
            end
        end
    end

    task automatic load_mem();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            load_img[i] = img[i];
            ref_mem[i]  = img[i];
        end
        tb_load = 1'b1;
        @(negedge clk);
        tb_load = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, input logic pe, input logic [DW-1:0] pat,
                         input bit track);
        exp_t e;
        int   l;
        int   lat;
        bit   bad;
        l   = int'(len);
        bad = (l > N);
        if (l == 0 || bad) lat = 1;
        else if (op)       lat = l + 1;
        else               lat = 2 * l + 1;
        @(negedge clk);
        op_i         = op;
        src_i        = src;
        dst_i        = dst;
        len_i        = len;
        cfg_pat_en_i = pe;
        pattern_i    = pat;
        start_i      = 1'b1;
        if (track) begin
            if (!bad) begin
                for (int i = 0; i < l; i++)
                    ref_mem[(int'(dst) + i) % N] = op ? (pe ? pat : FILL_W)
                                                      : ref_mem[(int'(src) + i) % N];
            end
            e.err      = bad;
            e.wd       = bad ? '0 : len;
            e.done_cyc = cyc + lat;
            e.busy_cyc = lat - 1;
            e.img      = ref_snapshot();
            sbq.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !done_o && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: %0d outcomes still pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic stray_start();
        if (busy_o) begin
            op_i         = 1'($urandom);
            src_i        = AW'($urandom);
            dst_i        = AW'($urandom);
            len_i        = LW'($urandom_range(1, 10));
            cfg_pat_en_i = 1'b1;
            pattern_i    = $urandom;
            start_i      = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        op_i         = 1'b0;
        src_i        = '0;
        dst_i        = '0;
        len_i        = '0;
        cfg_pat_en_i = 1'b0;
        pattern_i    = '0;
        tb_load      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_words_done", words_done_o, 0);
        chk("rst_mem_we", mif.we, 0);
        chk("rst_mem_a", mif.a, 0);
        chk("rst_mem_d", mif.d, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed: fill, copy, source wrap, forward overlap
        for (int i = 0; i < N; i++) img[i] = FILL_W;
        load_mem();
        issue(OP_FILL, 6'd0, 6'd4, 7'd3, 1'b1, 32'hA5A5_A5A5, 1);
        wait_idle();

        for (int i = 0; i < N; i++) img[i] = FILL_W;
        for (int i = 0; i < 4; i++) img[i] = DW'(i + 1);
        load_mem();
        issue(OP_COPY, 6'd0, 6'd10, 7'd4, 1'b0, 32'h0, 1);
        wait_idle();

        img[62] = 32'h7; img[63] = 32'h8; img[0] = 32'h9; img[1] = 32'hA;
        load_mem();
        issue(OP_COPY, 6'd62, 6'd30, 7'd4, 1'b0, 32'h0, 1);
        wait_idle();

        for (int i = 0; i < 4; i++) img[i] = DW'(i + 1);
        load_mem();
        issue(OP_COPY, 6'd0, 6'd1, 7'd3, 1'b0, 32'h0, 1);
        wait_idle();

        // Zero length, oversize length, start while busy, start during done
        issue(OP_FILL, 6'd0, 6'd5, 7'd0, 1'b1, 32'hDEAD_BEEF, 1);
        wait_idle();
        issue(OP_COPY, 6'd3, 6'd9, 7'd65, 1'b0, 32'h0, 1);
        wait_idle();
        issue(OP_COPY, 6'd0, 6'd20, 7'd6, 1'b0, 32'h0, 1);
        repeat (3) @(negedge clk);
        stray_start();
        wait_idle();
        issue(OP_FILL, 6'd0, 6'd40, 7'd2, 1'b1, 32'h1234_5678, 1);
        for (int k = 0; k < 20 && !done_o; k++) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_in_done_ignored", busy_o, 0);
        wait_idle();

        // Reset in the middle of a full-memory default fill
        for (int i = 0; i < N; i++) img[i] = DW'(i);
        load_mem();
        issue(OP_FILL, 6'd0, 6'd0, 7'd64, 1'b0, 32'h0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_rst_mem_we", mif.we, 0);
        chk("midop_rst_busy", busy_o, 0);
        chk("midop_rst_words_done", words_done_o, 0);
        chk("midop_rst_done", done_o, 0);
        for (int i = 0; i < 10; i++) ref_mem[i] = FILL_W;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_mem("midop_rst_mem", ref_snapshot());

        // Randomised operations against the reference model
        for (int t = 0; t < 40; t++) begin
            int r;
            logic [LW-1:0] l;
            if ($urandom_range(0, 4) == 0) begin
                for (int i = 0; i < N; i++) img[i] = $urandom;
                load_mem();
            end
            r = int'($urandom_range(0, 9));
            if (r == 0)      l = '0;
            else if (r == 1) l = LW'(N);
            else if (r == 2) l = LW'($urandom_range(N + 1, 2 ** LW - 1));
            else             l = LW'($urandom_range(1, 20));
            issue(1'($urandom), AW'($urandom), AW'($urandom), l, 1'($urandom), $urandom, 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                stray_start();
            end
            wait_idle();
        end

        wait_idle();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
